seq_pattern_tx: RTL
===================

SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001 SHALL have parameter PAT_W, default 4: pattern length in bits (2..16).
REQ-002 SHALL have parameter GAP_LEN, default 2: idle cycles between frames, used only when SEQ_TX_GAP_EN is defined (1..15).
REQ-003 SHALL have port clk, input, 1: single clock; all logic samples on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1: request to transmit; sampled only in IDLE.
REQ-006 SHALL have port pat_in, input, PAT_W: pattern, transmitted MSB first; latched when start is accepted.
REQ-007 SHALL have port rep_in, input, 4: frame count minus one (0 = 1 frame, 15 = 16 frames); latched when start is accepted.
REQ-008 SHALL have port ser_out, output, 1: serial data, registered.
REQ-009 SHALL have port ser_valid, output, 1: ser_out carries a pattern bit this cycle, registered.
REQ-010 SHALL have port busy, output, 1: high from the first bit cycle through the last bit cycle.
REQ-011 SHALL have port done, output, 1: one-cycle pulse after the final bit of the final frame.

Function
REQ-012 SHALL implement the FSM states IDLE, SEND, GAP and DONE, held in a 2-bit state register.
REQ-013 SHALL accept start only in IDLE; start at edge t latches pat_in and rep_in, and the MSB appears on ser_out with ser_valid=1 and busy=1 after edge t+1.
REQ-014 SHALL emit one bit per cycle in SEND, MSB first, using a bit index that counts down from PAT_W-1 to 0.
REQ-015 SHALL, after bit 0 with frames remaining, go to GAP (macro defined) or reload the index and continue in SEND with no bubble (macro undefined).
REQ-016 SHALL, after bit 0 of the last frame, enter DONE for exactly one cycle with done=1, ser_valid=0, ser_out=0 and busy=0, then return to IDLE.
REQ-017 SHALL hold ser_out=0 and ser_valid=0 in IDLE, GAP and DONE.
REQ-018 SHALL ignore start and any changes to pat_in and rep_in while not in IDLE; the latched copies govern the transfer.
REQ-019 SHALL NOT accept start in the DONE cycle; start sampled at the edge that returns the block to IDLE is accepted only on the following edge.
REQ-020 SHALL use a 4-bit frame counter loaded with rep_in and decremented at the end of each frame; the final frame is the one that ends with the counter at 0, and the counter SHALL NOT wrap.
REQ-021 SHALL, if the state register holds an illegal encoding, go to IDLE on the next edge with all outputs 0.

Reset
REQ-022 SHALL, with rst=1 at an edge, force IDLE and clear ser_out, ser_valid, busy, done and all counters, overriding start.
REQ-023 SHALL abort a transfer when rst is asserted mid-frame, with no done pulse; rst has priority over every other input.

Configuration
REQ-024 SHALL, with SEQ_TX_GAP_EN defined, insert GAP_LEN cycles of ser_valid=0 and busy=1 between consecutive frames.
REQ-025 SHALL, with SEQ_TX_GAP_EN undefined, omit the GAP state and gap counter, with frames sent back-to-back.

Structure
REQ-026 SHALL place the state encoding constants (IDLE=0, SEND=1, GAP=2, DONE=3) and the default values of PAT_W and GAP_LEN in the shared package seq_pkg.
REQ-027 SHALL be a single module; no sub-module is required.

Verification
REQ-028 SHALL cover: pat_in=4'b1101, rep_in=0, start pulse at edge t -> ser_out 1,1,0,1 with ser_valid=1 at t+1..t+4, done=1 at t+5, busy=0 at t+5.
REQ-029 SHALL cover: pat_in=4'b1101, rep_in=1, macro undefined -> 8 consecutive valid bits 11011101, then a single done pulse.
REQ-030 SHALL cover: pat_in=4'b1101, rep_in=1, SEQ_TX_GAP_EN defined with GAP_LEN=2 -> 1101, 2 cycles with ser_valid=0 and busy=1, then 1101, then done.
REQ-031 SHALL cover: start held high across the whole transfer with pat_in changed mid-frame -> the latched pattern is unchanged, and the next frame starts only after the post-DONE IDLE cycle.
REQ-032 SHALL cover: rst=1 asserted on the third bit -> all outputs 0 at the next edge, no done pulse, and a new start is accepted normally.
REQ-033 SHALL cover: loopback of ser_out into the team's 1101 Mealy detector with rep_in=2 and the macro undefined -> the detector's out pulses once per frame.

Source files
------------

// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - state encoding and parameter defaults shared by seq_pattern_tx
package seq_pkg;

  localparam int PAT_W_DEF   = 4;
  localparam int GAP_LEN_DEF = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - MSB-first serial pattern transmitter with repeat count
// SEQ_TX_GAP_EN inserts GAP_LEN idle cycles between frames; undefined gives back-to-back frames.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int PAT_W   = PAT_W_DEF,
  parameter int GAP_LEN = GAP_LEN_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [3:0]       rep_in,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] IDX_INIT = IDX_W'(PAT_W - 1);

  if (PAT_W < 2 || PAT_W > 16 || GAP_LEN < 1 || GAP_LEN > 15) begin : g_param_check
    $error("seq_pattern_tx: PAT_W or GAP_LEN out of range");
  end

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PAT_W-1:0] r_pat;
  logic [IDX_W-1:0] r_idx;
  logic [3:0]       r_frm_cnt;
  logic             w_load;
  logic             w_frm_end;
  logic             w_last;
  logic             w_ser_out_nxt;
  logic             w_ser_valid_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
`ifdef SEQ_TX_GAP_EN
  logic [3:0]       r_gap_cnt;
`endif

  assign w_frm_end = (r_state == SEND) && (r_idx == '0);
  assign w_last    = (r_frm_cnt == 4'd0);

  // Outputs are registered from the current state, so they trail the state by one cycle.
  always_comb begin
    w_state_nxt     = IDLE;
    w_load          = 1'b0;
    w_ser_out_nxt   = 1'b0;
    w_ser_valid_nxt = 1'b0;
    w_busy_nxt      = 1'b0;
    w_done_nxt      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = SEND;
          w_load      = 1'b1;
        end
      end
      SEND: begin
        w_ser_out_nxt   = r_pat[r_idx];
        w_ser_valid_nxt = 1'b1;
        w_busy_nxt      = 1'b1;
        if (!w_frm_end) begin
          w_state_nxt = SEND;
        end else if (w_last) begin
          w_state_nxt = DONE;
        end else begin
`ifdef SEQ_TX_GAP_EN
          w_state_nxt = GAP;
`else
          w_state_nxt = SEND;
`endif
        end
      end
`ifdef SEQ_TX_GAP_EN
      GAP: begin
        w_busy_nxt  = 1'b1;
        w_state_nxt = (r_gap_cnt == 4'd0) ? SEND : GAP;
      end
`endif
      DONE: begin
        w_done_nxt  = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      ser_out   <= w_ser_out_nxt;
      ser_valid <= w_ser_valid_nxt;
      busy      <= w_busy_nxt;
      done      <= w_done_nxt;
    end
  end

  // Frame counter only decrements when nonzero, so it never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pat     <= '0;
      r_idx     <= '0;
      r_frm_cnt <= 4'd0;
    end else if (w_load) begin
      r_pat     <= pat_in;
      r_idx     <= IDX_INIT;
      r_frm_cnt <= rep_in;
    end else if (r_state == SEND) begin
      if (!w_frm_end) begin
        r_idx <= r_idx - 1'b1;
      end else begin
        r_idx <= IDX_INIT;
        if (!w_last) begin
          r_frm_cnt <= r_frm_cnt - 4'd1;
        end
      end
    end
  end

`ifdef SEQ_TX_GAP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gap_cnt <= 4'd0;
    end else if (w_frm_end && !w_last) begin
      r_gap_cnt <= 4'(GAP_LEN - 1);
    end else if ((r_state == GAP) && (r_gap_cnt != 4'd0)) begin
      r_gap_cnt <= r_gap_cnt - 4'd1;
    end
  end
`endif

endmodule
